// File: rtl/eightbitreg_pkg.sv
// Shared constants and helpers for the eight_bit_reg holding register.
// The optional parity output is enabled by defining EIGHTBITREG_PARITY_EN.
package eightbitreg_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam logic [DefaultWidth-1:0] DefaultRstVal = '0;

    // Widest value the parity helper accepts; narrower data is zero-extended,
    // which leaves the parity unchanged.
    localparam int unsigned ParMaxWidth = 64;

    // Even parity bit: 1 when the value holds an odd number of ones.
    function automatic logic parity(input logic [ParMaxWidth-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/eightbitreg_bit.sv
// Single storage bit: async active-low reset, sync active-high clear,
// both loading the supplied reset value.
module eightbitreg_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic d_i,
    input  logic rst_val_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    // Clear takes priority over the data load.
    always_comb begin
        q_d = d_i;
        if (clear_i) begin
            q_d = rst_val_i;
        end
    end

    // State flop; reset acts immediately, independent of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= rst_val_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/eight_bit_reg.sv
// Parallel-load holding register, one clock of latency, no enable.
// Define EIGHTBITREG_PARITY_EN to add OUT_PAR, a registered even parity of
// the value loaded into OUT (always consistent with OUT in the same cycle).
module eight_bit_reg
    import eightbitreg_pkg::*;
#(
    parameter int unsigned          WIDTH   = DefaultWidth,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] IN,
`ifdef EIGHTBITREG_PARITY_EN
    output logic             OUT_PAR,
`endif
    output logic [WIDTH-1:0] OUT
);

    // One flop per data bit; OUT comes straight from the flops.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        eightbitreg_bit u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear_i   (clear),
            .d_i       (IN[i]),
            .rst_val_i (RST_VAL[i]),
            .q_o       (OUT[i])
        );
    end

`ifdef EIGHTBITREG_PARITY_EN
    // Parity is computed on the value being loaded, not on OUT, so the parity
    // flop and the data flops always update together. Assumes WIDTH <= 64.
    logic [ParMaxWidth-1:0] par_in_ext;
    logic [ParMaxWidth-1:0] par_rst_ext;

    assign par_in_ext  = ParMaxWidth'(IN);
    assign par_rst_ext = ParMaxWidth'(RST_VAL);

    eightbitreg_bit u_par (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .d_i       (parity(par_in_ext)),
        .rst_val_i (parity(par_rst_ext)),
        .q_o       (OUT_PAR)
    );
`endif

endmodule

// File: tb/tb_eight_bit_reg.sv
// Scoreboard bench for eight_bit_reg: two instances (reset value 8'h00 and
// 8'h5A) share all inputs. Stimulus pushes hand-computed expectations into a
// queue; a monitor process pops and compares them. Parity is checked only
// when EIGHTBITREG_PARITY_EN is defined.
module tb_eight_bit_reg;

    typedef struct {
        string      name;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       par_a;
        logic       par_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout_a;
    logic [7:0] dout_b;
    logic       par_a;
    logic       par_b;

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    eight_bit_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .IN      (din),
`ifdef EIGHTBITREG_PARITY_EN
        .OUT_PAR (par_a),
`endif
        .OUT     (dout_a)
    );

    eight_bit_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h5A)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .IN      (din),
`ifdef EIGHTBITREG_PARITY_EN
        .OUT_PAR (par_b),
`endif
        .OUT     (dout_b)
    );

`ifndef EIGHTBITREG_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif

    task automatic expect_out(input string name, input logic [7:0] ea, input logic [7:0] eb,
                              input logic pa, input logic pb);
        exp_t e;
        e.name  = name;
        e.exp_a = ea;
        e.exp_b = eb;
        e.par_a = pa;
        e.par_b = pb;
        sb_q.push_back(e);
        -> chk_ev;
    endtask

    // Monitor: drain the scoreboard each time the stimulus marks a sample point.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (dout_a !== e.exp_a) begin
                    errors++;
                    $display("FAIL %s out_a: got %h expected %h", e.name, dout_a, e.exp_a);
                end
                checks++;
                if (dout_b !== e.exp_b) begin
                    errors++;
                    $display("FAIL %s out_b: got %h expected %h", e.name, dout_b, e.exp_b);
                end
`ifdef EIGHTBITREG_PARITY_EN
                checks++;
                if (par_a !== e.par_a) begin
                    errors++;
                    $display("FAIL %s par_a: got %b expected %b", e.name, par_a, e.par_a);
                end
                checks++;
                if (par_b !== e.par_b) begin
                    errors++;
                    $display("FAIL %s par_b: got %b expected %b", e.name, par_b, e.par_b);
                end
`endif
            end
        end
    end

    initial begin
        // Async reset with no clock edge yet (first posedge at t=5).
        #1 rst_n = 1'b0;
        din = 8'hAA;
        #2 expect_out("reset_async", 8'h00, 8'h5A, 1'b0, 1'b0);

        // Reset holds across clock edges while IN toggles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 expect_out("reset_hold", 8'h00, 8'h5A, 1'b0, 1'b0);
            din = ~din;
        end

        // Release reset, load a sequence of values.
        @(negedge clk);
        rst_n = 1'b1;
        din = 8'h00;
        @(posedge clk);
        #1 expect_out("load_00", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        din = 8'hAA;
        @(posedge clk);
        #1 expect_out("load_aa", 8'hAA, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        din = 8'hFF;
        @(posedge clk);
        #1 expect_out("load_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);

        // Clear for two edges, then release with IN = FF.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 expect_out("clear_1", 8'h00, 8'h5A, 1'b0, 1'b0);
        @(posedge clk);
        #1 expect_out("clear_2", 8'h00, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1 expect_out("clear_release", 8'hFF, 8'hFF, 1'b0, 1'b0);

        // Reset pulse mid-cycle while clear is high.
        @(negedge clk);
        clear = 1'b1;
        #2 rst_n = 1'b0;
        #1 expect_out("rst_mid_cycle", 8'h00, 8'h5A, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 expect_out("rst_clear_hold", 8'h00, 8'h5A, 1'b0, 1'b0);

        // IN changes in the same time step as the edge: pre-edge value wins.
        // Driven non-blocking to model an upstream flop on the same clock.
        @(negedge clk);
        clear = 1'b0;
        din = 8'h0F;
        @(posedge clk);
        din <= 8'hF0;
        #1 expect_out("edge_pre", 8'h0F, 8'h0F, 1'b0, 1'b0);
        @(posedge clk);
        #1 expect_out("edge_post", 8'hF0, 8'hF0, 1'b0, 1'b0);

        // Odd-weight value sets parity.
        @(negedge clk);
        din = 8'h01;
        @(posedge clk);
        #1 expect_out("load_01", 8'h01, 8'h01, 1'b1, 1'b1);

        // Bounded wait for the monitor to drain the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            -> chk_ev;
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
